// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, constants and golden ALU model for the ALU BIST
//
// Purpose : common definitions imported by alu_bist and alu_lfsr16.
//   DW          operand/result width (7)
//   OP_ADD/SUB  opcode encodings
//   state_t     BIST controller states
//   alu_out_t   {res, cf, gz} bundle returned by golden_alu()
package alu_pkg;

  localparam int DW = 7;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          cf;
    logic          gz;
  } alu_out_t;

  // Reference behaviour: add gives an 8-bit sum split into {cf,res};
  // subtract wraps modulo 128 and flags a borrow when a < b.
  function automatic alu_out_t golden_alu(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic          op
  );
    alu_out_t    r;
    logic [DW:0] w;
    if (op == OP_SUB) begin
      w    = {1'b0, a} - {1'b0, b};
      r.cf = (a < b);
    end else begin
      w    = {1'b0, a} + {1'b0, b};
      r.cf = w[DW];
    end
    r.res = w[DW-1:0];
    r.gz  = (r.res != '0);
    return r;
  endfunction

endpackage

// File: rtl/alu_lfsr16.sv
// rtl/alu_lfsr16.sv - 16-bit Fibonacci LFSR vector source (taps 16,14,13,11)
//
// Purpose : pseudo-random vector generator for the BIST.
// Ports   :
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, loads SEED
//   i_load   in   reload SEED (takes priority over i_en)
//   i_en     in   advance one step
//   o_state  out  current 16-bit LFSR state
module alu_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_en,
  output logic [15:0] o_state
);
  import alu_pkg::*;

  logic [15:0] r_lfsr;
  logic        w_fb;

  // Tap positions 16,14,13,11 map to bits 15,13,12,10; shift toward the MSB.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - built-in self test controller for a 7-bit combinational ALU
//
// Purpose : drives vectors (LFSR or one directed vector) into an external ALU,
//           compares its outputs with the golden model and reports the result.
// Ports   :
//   clk, rst_n                 clock / asynchronous active-low reset
//   start                      one-cycle pulse, begins a run when idle
//   dir_mode                   1 = single directed vector, 0 = LFSR run
//   dir_a, dir_b, dir_op       directed vector, captured at start
//   alu_a, alu_b, alu_op       registered operands to the ALU under test
//   alu_res, alu_cf, alu_gz    ALU responses
//   busy                       run in progress (2 cycles per vector)
//   done                       one-cycle pulse after the last vector
//   pass                       1 iff no mismatches, valid from done to next start
//   err_cnt                    mismatching vectors (saturating)
//   fail_idx                   index of first mismatch, 8'hFF if none
module alu_bist
  import alu_pkg::*;
#(
  parameter int          NUM_VEC = 15,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dir_mode,
  input  logic [DW-1:0] dir_a,
  input  logic [DW-1:0] dir_b,
  input  logic          dir_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_op,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_cf,
  input  logic          alu_gz,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [7:0]    fail_idx
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

  state_t        r_state;
  state_t        w_next_state;

  logic          r_dir_mode;
  logic [DW-1:0] r_dir_a;
  logic [DW-1:0] r_dir_b;
  logic          r_dir_op;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic          r_alu_op;
  logic [7:0]    r_idx;
  logic [7:0]    r_err_cnt;
  logic [7:0]    r_fail_idx;
  logic          r_pass;

  logic [15:0]   w_lfsr;
  logic          w_unused_lfsr14;
  logic          w_start_ok;
  logic          w_last;
  logic [DW-1:0] w_vec_a;
  logic [DW-1:0] w_vec_b;
  logic          w_vec_op;
  alu_out_t      w_gold;
  logic          w_mismatch;

  assign w_start_ok = (r_state == ST_IDLE) && start;

  // Reloads on every accepted start so repeated runs see the same sequence.
  alu_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_start_ok),
    .i_en    (r_state == ST_SAMPLE),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr14 = w_lfsr[14];

  assign w_vec_a  = r_dir_mode ? r_dir_a  : w_lfsr[6:0];
  assign w_vec_b  = r_dir_mode ? r_dir_b  : w_lfsr[13:7];
  assign w_vec_op = r_dir_mode ? r_dir_op : w_lfsr[15];

  // A directed run is always a single vector.
  assign w_last = r_dir_mode || (r_idx == LAST_IDX);

  assign w_gold     = golden_alu(r_alu_a, r_alu_b, r_alu_op);
  assign w_mismatch = (alu_res != w_gold.res) || (alu_cf != w_gold.cf) ||
                      (alu_gz != w_gold.gz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_APPLY;
      end
      ST_APPLY: begin
        busy         = 1'b1;
        w_next_state = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy         = 1'b1;
        w_next_state = w_last ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_mode <= 1'b0;
      r_dir_a    <= '0;
      r_dir_b    <= '0;
      r_dir_op   <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= 1'b0;
      r_idx      <= 8'd0;
      r_err_cnt  <= 8'd0;
      r_fail_idx <= 8'hFF;
      r_pass     <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_dir_mode <= dir_mode;
        r_dir_a    <= dir_a;
        r_dir_b    <= dir_b;
        r_dir_op   <= dir_op;
        r_idx      <= 8'd0;
        r_err_cnt  <= 8'd0;
        r_fail_idx <= 8'hFF;
        r_pass     <= 1'b0;
      end

      if (r_state == ST_APPLY) begin
        r_alu_a  <= w_vec_a;
        r_alu_b  <= w_vec_b;
        r_alu_op <= w_vec_op;
      end

      if (r_state == ST_SAMPLE) begin
        if (w_mismatch) begin
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          // err_cnt never returns to zero within a run, so this marks the first miss.
          if (r_err_cnt == 8'd0) r_fail_idx <= r_idx;
        end
        // pass must be valid in the same cycle done rises, so fold in this vector.
        if (w_last) begin
          r_pass <= (r_err_cnt == 8'd0) && !w_mismatch;
        end else begin
          r_idx <= r_idx + 8'd1;
        end
      end
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign fail_idx = r_fail_idx;

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - scoreboard testbench for alu_bist
module tb_alu_bist;

  localparam int          NV   = 15;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir_mode = 1'b0;
  logic [6:0] dir_a = 7'd0;
  logic [6:0] dir_b = 7'd0;
  logic       dir_op = 1'b0;
  logic [6:0] alu_a, alu_b, alu_res;
  logic       alu_op, alu_cf, alu_gz;
  logic       busy, done, pass;
  logic [7:0] err_cnt, fail_idx;
  logic       flt_cf0 = 1'b0;
  logic       flt_gz1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_bist #(.NUM_VEC(NV), .SEED(SEED)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dir_mode (dir_mode),
    .dir_a    (dir_a),
    .dir_b    (dir_b),
    .dir_op   (dir_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_cf   (alu_cf),
    .alu_gz   (alu_gz),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_idx (fail_idx)
  );

  // ALU under test, with optional stuck-at faults on the flags.
  logic [7:0] alu_wide;
  always_comb begin
    alu_wide = alu_op ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    alu_res  = alu_wide[6:0];
    alu_cf   = alu_wide[7] & ~flt_cf0;
    alu_gz   = (alu_wide[6:0] != 7'd0) | flt_gz1;
  end

  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
    logic       op;
  } vec_t;

  typedef struct {
    logic [7:0] err;
    logic [7:0] fidx;
    logic       pass;
    int         busy;
  } res_t;

  vec_t vq[$];
  res_t rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input logic [6:0] a, input logic [6:0] b, input logic op);
    vec_t v;
    v.a = a; v.b = b; v.op = op;
    vq.push_back(v);
  endtask

  task automatic push_res(input logic [7:0] e, input logic [7:0] f, input logic p, input int bz);
    res_t r;
    r.err = e; r.fidx = f; r.pass = p; r.busy = bz;
    rq.push_back(r);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // A stuck flag only counts as an error where it differs from the true flag.
  function automatic bit vec_bad(input vec_t v, input bit cf0, input bit gz1);
    logic [7:0] w;
    w = v.op ? ({1'b0, v.a} - {1'b0, v.b}) : ({1'b0, v.a} + {1'b0, v.b});
    return (cf0 && w[7]) || (gz1 && (w[6:0] == 7'd0));
  endfunction

  task automatic push_lfsr_run(input bit cf0, input bit gz1);
    logic [15:0] s;
    res_t        r;
    vec_t        v;
    s      = SEED;
    r.err  = 8'd0;
    r.fidx = 8'hFF;
    r.busy = 2 * NV;
    for (int i = 0; i < NV; i++) begin
      v.op = s[15]; v.b = s[13:7]; v.a = s[6:0];
      vq.push_back(v);
      if (vec_bad(v, cf0, gz1)) begin
        if (r.err == 8'd0) r.fidx = 8'(i);
        r.err = r.err + 8'd1;
      end
      s = lfsr_next(s);
    end
    r.pass = (r.err == 8'd0);
    rq.push_back(r);
  endtask

  task automatic pulse_start(input logic dm, input logic [6:0] a, input logic [6:0] b, input logic op);
    @(posedge clk); #1;
    dir_mode = dm; dir_a = a; dir_b = b; dir_op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the directed inputs to prove they were captured at start.
    dir_a = 7'h2A; dir_b = 7'h15; dir_op = ~op; dir_mode = ~dm;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic run(input logic dm, input logic [6:0] a, input logic [6:0] b, input logic op);
    pulse_start(dm, a, b, op);
    wait_done();
    @(posedge clk); #1;
  endtask

  // Monitor: compares operands in every SAMPLE cycle and results on every done.
  int   bc = 0;
  vec_t mv;
  res_t mr;
  always @(negedge clk) begin
    if (!rst_n) begin
      bc = 0;
    end else begin
      if (busy) begin
        bc++;
        if (bc % 2 == 0) begin
          if (vq.size() == 0) begin
            checks++; errors++;
            $display("FAIL vec_unexpected: vector at busy cycle %0d with none expected", bc);
          end else begin
            mv = vq.pop_front();
            check("alu_a", alu_a, mv.a);
            check("alu_b", alu_b, mv.b);
            check("alu_op", alu_op, mv.op);
          end
        end
      end
      if (done) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: done with no run expected");
        end else begin
          mr = rq.pop_front();
          check("err_cnt", err_cnt, mr.err);
          check("fail_idx", fail_idx, mr.fidx);
          check("pass", pass, mr.pass);
          check("busy_cycles", bc, mr.busy);
          check("vec_left", vq.size(), 0);
        end
        bc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_fail_idx", fail_idx, 8'hFF);
    check("rst_alu_a", alu_a, 7'd0);
    check("rst_alu_op", alu_op, 1'b0);
    rst_n = 1'b1;

    // 127 + 1 = 128: res 0, cf 1, gz 0
    push_vec(7'd127, 7'd1, 1'b0);
    push_res(8'd0, 8'hFF, 1'b1, 2);
    run(1'b1, 7'd127, 7'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pass_hold", pass, 1'b1);

    // 5 - 9 = 124 with borrow
    push_vec(7'd5, 7'd9, 1'b1);
    push_res(8'd0, 8'hFF, 1'b1, 2);
    run(1'b1, 7'd5, 7'd9, 1'b1);

    flt_cf0 = 1'b1;
    push_vec(7'd5, 7'd9, 1'b1);
    push_res(8'd1, 8'd0, 1'b0, 2);
    run(1'b1, 7'd5, 7'd9, 1'b1);
    flt_cf0 = 1'b0;

    // 5 - 5 = 0: gz stuck-1 must be caught
    flt_gz1 = 1'b1;
    push_vec(7'd5, 7'd5, 1'b1);
    push_res(8'd1, 8'd0, 1'b0, 2);
    run(1'b1, 7'd5, 7'd5, 1'b1);
    flt_gz1 = 1'b0;

    // LFSR runs, twice to confirm the sequence repeats
    push_lfsr_run(1'b0, 1'b0);
    run(1'b0, 7'd0, 7'd0, 1'b0);
    push_lfsr_run(1'b0, 1'b0);
    run(1'b0, 7'd0, 7'd0, 1'b0);

    flt_gz1 = 1'b1;
    push_lfsr_run(1'b0, 1'b1);
    run(1'b0, 7'd0, 7'd0, 1'b0);
    flt_gz1 = 1'b0;

    flt_cf0 = 1'b1;
    push_lfsr_run(1'b1, 1'b0);
    run(1'b0, 7'd0, 7'd0, 1'b0);
    flt_cf0 = 1'b0;

    // Reset during the APPLY cycle of vector 7
    push_lfsr_run(1'b0, 1'b0);
    pulse_start(1'b0, 7'd0, 7'd0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_pass", pass, 1'b0);
    check("midrst_err_cnt", err_cnt, 8'd0);
    check("midrst_fail_idx", fail_idx, 8'hFF);
    check("midrst_alu_a", alu_a, 7'd0);
    check("midrst_alu_b", alu_b, 7'd0);
    check("midrst_alu_op", alu_op, 1'b0);
    vq.delete();
    rq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_idle", busy, 1'b0);
    push_lfsr_run(1'b0, 1'b0);
    run(1'b0, 7'd0, 7'd0, 1'b0);

    // start during busy and during DONE is ignored
    push_lfsr_run(1'b0, 1'b0);
    pulse_start(1'b0, 7'd0, 7'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    dir_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no_restart_busy", busy, 1'b0);
      @(posedge clk); #1;
    end
    check("queues_drained", vq.size() + rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter NUM_VEC, default 15, number of vectors per run (1..255).
REQ-002 Parameter SEED, default 16'hACE1, LFSR seed, nonzero.
REQ-003 clk  input  1  single clock; all flops rising-edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a run when idle.
REQ-006 dir_mode  input  1  1 = single directed vector from dir_a/dir_b/dir_op; 0 = LFSR run.
REQ-007 dir_a, dir_b  input  7 each  directed operands.
REQ-008 dir_op  input  1  directed opcode.
REQ-009 alu_a, alu_b  output  7 each  operands to the combinational ALU under test.
REQ-010 alu_op  output  1  opcode to the ALU.
REQ-011 alu_res  input  7  ALU result.
REQ-012 alu_cf  input  1  ALU carry/borrow flag.
REQ-013 alu_gz  input  1  ALU nonzero-result flag.
REQ-014 busy  output  1  run in progress.
REQ-015 done  output  1  one-cycle pulse at end of run.
REQ-016 pass  output  1  valid from done until next start; 1 iff err_cnt == 0.
REQ-017 err_cnt  output  8  mismatching vectors this run; saturates at 255.
REQ-018 fail_idx  output  8  index of first mismatching vector; 8'hFF if none.

Function
REQ-019 Golden model: op=0 -> {cf,res} = a+b (8-bit sum); op=1 -> res = (a-b) mod 128, cf = (a<b); gz = (res != 0).
REQ-020 FSM states: IDLE, APPLY, SAMPLE, DONE; IDLE->APPLY on start; APPLY->SAMPLE always; SAMPLE->APPLY if vectors remain, else DONE; DONE->IDLE always.
REQ-021 start while busy is ignored; start in DONE is ignored.
REQ-022 In APPLY, alu_a/alu_b/alu_op are registered to the current vector; values hold stable through SAMPLE.
REQ-023 In SAMPLE, alu_res/alu_cf/alu_gz are compared with the golden model of the held operands; any field mismatch is one error.
REQ-024 Per vector: exactly 2 cycles; a run of N vectors has busy high for 2N cycles; done asserts the cycle after the last SAMPLE.
REQ-025 LFSR: 16-bit Fibonacci, taps 16,14,13,11; vector = {op=lfsr[15], b=lfsr[13:7], a=lfsr[6:0]}; advances once per SAMPLE.
REQ-026 LFSR reloads SEED on every start; identical runs produce identical vector sequences.
REQ-027 dir_mode sampled at start; if 1, run is exactly one vector using dir_* sampled at start.
REQ-028 err_cnt, fail_idx cleared on start; fail_idx written only on first mismatch.
REQ-029 Vector index counter is 8 bits, counts 0..NUM_VEC-1, no wrap within a run.
REQ-030 err_cnt at 255 holds at 255 on further mismatches.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, busy 0, done 0, pass 0, err_cnt 0, fail_idx 8'hFF, alu_a/alu_b 0, alu_op 0, LFSR = SEED.
REQ-032 Reset mid-run aborts without done; the next start begins a fresh run.

Structure
REQ-033 Shared package alu_pkg holds: state enum, OP_ADD=0/OP_SUB=1 constants, data width 7, golden-model function.
REQ-034 One sub-module alu_lfsr16 (load, enable, state out); remaining logic in alu_bist.

Verification
REQ-035 Directed add: dir_mode=1, a=127, b=1, op=0 with correct ALU -> ALU sees 127/1/0, res=0, cf=1, gz=0; done after 2 busy cycles, pass=1, fail_idx=FF.
REQ-036 Directed sub: a=5, b=9, op=1 -> golden res=124, cf=1, gz=1; correct ALU gives pass=1; ALU with cf stuck-0 gives err_cnt=1, fail_idx=0, pass=0.
REQ-037 LFSR run, correct ALU, NUM_VEC=15 -> busy 30 cycles, one done pulse, pass=1, err_cnt=0; a second run reproduces the same 15 vectors.
REQ-038 LFSR run, ALU with gz stuck-1 -> err_cnt equals count of vectors with res==0 in model; fail_idx = first such index, else pass=1.
REQ-039 Assert rst_n low at vector 7 -> outputs at reset values immediately, no done; new start completes a full 15-vector run.
REQ-040 start pulses during busy and during DONE -> no restart, run length unchanged.
